// File: rtl/edge_pkg.sv
// ---------------------------------------------------------------------------
// edge_pkg
// Shared definitions for the Sobel edge pipeline: writer FSM states, pixel
// width/limits, default frame geometry and the gradient-to-pixel conversion.
// ---------------------------------------------------------------------------
package edge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int              PIX_W      = 8;
  localparam logic [PIX_W-1:0] PIX_MAX   = 8'd255;
  localparam int              DEF_IMG_W  = 256;
  localparam int              DEF_IMG_H  = 256;
  localparam int              DEF_GRAD_W = 11;

  // thresh == 0 saturates the magnitude into 8 bits; any other value turns
  // the output into a binary edge map. Both compares are unsigned, full width.
  function automatic logic [PIX_W-1:0] grad_to_pix(input logic [31:0] grad,
                                                   input logic [31:0] thresh);
    logic [PIX_W-1:0] pix;
    if (thresh == 32'd0) begin
      if (grad > 32'd255) begin
        pix = PIX_MAX;
      end else begin
        pix = grad[PIX_W-1:0];
      end
    end else begin
      if (grad >= thresh) begin
        pix = PIX_MAX;
      end else begin
        pix = 8'd0;
      end
    end
    return pix;
  endfunction

endpackage

// File: rtl/edge_frame_ram.sv
// ---------------------------------------------------------------------------
// edge_frame_ram
// Simple dual-port frame buffer, 8-bit x 2**ADDR_W: one write port, one
// synchronous read-first read port with 1-cycle latency.
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset (read register only)
//   i_we       write enable
//   i_wr_addr  write address
//   i_wr_data  write data
//   i_rd_addr  read address
//   o_rd_data  read data, registered
// ---------------------------------------------------------------------------
module edge_frame_ram
  import edge_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [PIX_W-1:0]  i_wr_data,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [PIX_W-1:0]  o_rd_data
);

  logic [PIX_W-1:0] r_mem [0:(2**ADDR_W)-1];

  // Write port; contents deliberately not reset so the array maps to block RAM.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Read port: samples the array before this edge's write lands (read-first).
  always_ff @(posedge clk) begin
    if (rst) begin
      o_rd_data <= 8'd0;
    end else begin
      o_rd_data <= r_mem[i_rd_addr];
    end
  end

endmodule

// File: rtl/edge_frame_writer.sv
// ---------------------------------------------------------------------------
// edge_frame_writer
// Sink of the Sobel pipeline: zero-fills the IMG_W x IMG_H frame buffer, then
// writes each incoming interior gradient (converted to 8 bits) at its
// row*IMG_W+col address in raster order.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   i_start         pulse: begin a frame (IDLE/DONE only)
//   i_in_valid      gradient sample valid
//   o_in_ready      writer accepts a sample this cycle
//   i_in_grad       unsigned gradient magnitude
//   o_busy          high in CLEAR or WRITE
//   o_frame_done    high in DONE
//   i_rd_addr       readout address
//   o_rd_data       pixel at i_rd_addr, 1-cycle latency
// ---------------------------------------------------------------------------
module edge_frame_writer
  import edge_pkg::*;
#(
  parameter int          IMG_W  = DEF_IMG_W,
  parameter int          IMG_H  = DEF_IMG_H,
  parameter int          GRAD_W = DEF_GRAD_W,
  parameter int          ADDR_W = 16,
  parameter int unsigned THRESH = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [GRAD_W-1:0] i_in_grad,
  output logic              o_busy,
  output logic              o_frame_done,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [PIX_W-1:0]  o_rd_data
);

  localparam logic [ADDR_W-1:0] FRAME_LAST = ADDR_W'(IMG_W * IMG_H - 1);
  localparam logic [ADDR_W-1:0] COL_LAST   = ADDR_W'(IMG_W - 2);
  localparam logic [ADDR_W-1:0] ROW_LAST   = ADDR_W'(IMG_H - 2);
  localparam logic [ADDR_W-1:0] ONE        = ADDR_W'(1);

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_clr_addr, w_clr_nxt;
  logic [ADDR_W-1:0] r_row, w_row_nxt;
  logic [ADDR_W-1:0] r_col, w_col_nxt;
  logic              r_in_ready, r_busy, r_frame_done;
  logic              w_xfer, w_we, w_ram_we;
  logic [ADDR_W-1:0] w_wr_addr, w_pix_addr;
  logic [PIX_W-1:0]  w_wr_data, w_pix;

  assign w_xfer     = (r_state == ST_WRITE) && i_in_valid && r_in_ready;
  assign w_pix_addr = r_row * ADDR_W'(IMG_W) + r_col;
  assign w_pix      = grad_to_pix(32'(i_in_grad), 32'(THRESH));
  // A write in the cycle rst is sampled is dropped along with the frame.
  assign w_ram_we   = w_we && !rst;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, counter advance and frame-buffer write port.
  always_comb begin
    w_state_nxt = r_state;
    w_clr_nxt   = r_clr_addr;
    w_row_nxt   = r_row;
    w_col_nxt   = r_col;
    w_we        = 1'b0;
    w_wr_addr   = r_clr_addr;
    w_wr_data   = 8'd0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_state_nxt = ST_CLEAR;
          w_clr_nxt   = '0;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        w_we = 1'b1;
        if (r_clr_addr == FRAME_LAST) begin
          w_state_nxt = ST_WRITE;
          w_clr_nxt   = '0;
          w_row_nxt   = ONE;
          w_col_nxt   = ONE;
        end else begin
          w_clr_nxt = r_clr_addr + ONE;
        end
      end
      ST_WRITE: begin
        w_wr_addr = w_pix_addr;
        w_wr_data = w_pix;
        if (w_xfer) begin
          w_we = 1'b1;
          if (r_col == COL_LAST) begin
            w_col_nxt = ONE;
            if (r_row == ROW_LAST) begin
              w_state_nxt = ST_DONE;
            end else begin
              w_row_nxt = r_row + ONE;
            end
          end else begin
            w_col_nxt = r_col + ONE;
          end
        end else begin
          w_we = 1'b0;
        end
      end
      ST_DONE: begin
        if (i_start) begin
          w_state_nxt = ST_CLEAR;
          w_clr_nxt   = '0;
        end else begin
          w_state_nxt = ST_DONE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Counters and status outputs; outputs are decoded from the next state so
  // they are registered yet line up with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_clr_addr   <= '0;
      r_row        <= '0;
      r_col        <= '0;
      r_in_ready   <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_clr_addr   <= w_clr_nxt;
      r_row        <= w_row_nxt;
      r_col        <= w_col_nxt;
      r_in_ready   <= (w_state_nxt == ST_WRITE);
      r_busy       <= (w_state_nxt == ST_CLEAR) || (w_state_nxt == ST_WRITE);
      r_frame_done <= (w_state_nxt == ST_DONE);
    end
  end

  assign o_in_ready   = r_in_ready;
  assign o_busy       = r_busy;
  assign o_frame_done = r_frame_done;

  edge_frame_ram #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk       (clk),
    .rst       (rst),
    .i_we      (w_ram_we),
    .i_wr_addr (w_wr_addr),
    .i_wr_data (w_wr_data),
    .i_rd_addr (i_rd_addr),
    .o_rd_data (o_rd_data)
  );

endmodule

// File: tb/tb_edge_frame_writer.sv
// ---------------------------------------------------------------------------
// tb_edge_frame_writer
// Directed bench for edge_frame_writer on an 8x6 frame (24 interior samples).
// Two instances share all inputs: dut saturates (THRESH=0), dut_t thresholds
// at 100, so every frame exercises both conversion modes.
// ---------------------------------------------------------------------------
module tb_edge_frame_writer;

  logic        clk = 1'b0;
  logic        rst, start, in_valid;
  logic [10:0] in_grad;
  logic [5:0]  rd_addr;
  logic        s_ready, s_busy, s_done;
  logic        t_ready, t_busy, t_done;
  logic [7:0]  s_rd, t_rd;

  int n_cmp = 0;
  int n_bad = 0;
  int grads [24];
  int pulse_at = -1;

  always #5 clk = ~clk;

  edge_frame_writer #(.IMG_W(8), .IMG_H(6), .GRAD_W(11), .ADDR_W(6), .THRESH(0)) dut (
    .clk(clk), .rst(rst), .i_start(start), .i_in_valid(in_valid), .o_in_ready(s_ready),
    .i_in_grad(in_grad), .o_busy(s_busy), .o_frame_done(s_done), .i_rd_addr(rd_addr),
    .o_rd_data(s_rd));

  edge_frame_writer #(.IMG_W(8), .IMG_H(6), .GRAD_W(11), .ADDR_W(6), .THRESH(100)) dut_t (
    .clk(clk), .rst(rst), .i_start(start), .i_in_valid(in_valid), .o_in_ready(t_ready),
    .i_in_grad(in_grad), .o_busy(t_busy), .o_frame_done(t_done), .i_rd_addr(rd_addr),
    .o_rd_data(t_rd));

  function automatic int exp_pix(int g, int th);
    if (th == 0) return (g > 255) ? 255 : g;
    return (g >= th) ? 255 : 0;
  endfunction

  // Expected frame-buffer byte: interior rows 1..4, cols 1..6, border zero.
  function automatic int exp_at(int a, int th);
    int r, c;
    r = a / 8;
    c = a % 8;
    if (r >= 1 && r <= 4 && c >= 1 && c <= 6) return exp_pix(grads[(r-1)*6 + c-1], th);
    return 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic verify_frame(input string tag);
    for (int a = 0; a < 48; a++) begin
      rd_addr = 6'(a);
      tick();
      n_cmp++;
      if (s_rd !== 8'(exp_at(a, 0))) begin
        n_bad++;
        $display("FAIL %s sat addr %0d: got %0d want %0d", tag, a, s_rd, exp_at(a, 0));
      end
      n_cmp++;
      if (t_rd !== 8'(exp_at(a, 100))) begin
        n_bad++;
        $display("FAIL %s thr addr %0d: got %0d want %0d", tag, a, t_rd, exp_at(a, 100));
      end
    end
  endtask

  task automatic start_frame(input string tag);
    int n;
    start = 1'b1;
    tick();
    start = 1'b0;
    n_cmp++;
    if (s_busy !== 1'b1 || s_done !== 1'b0 || s_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL %s enter_clear: busy=%b done=%b ready=%b want 1 0 0", tag, s_busy, s_done, s_ready);
    end
    n = 0;
    while (s_ready !== 1'b1 && n < 200) begin
      n++;
      tick();
    end
    n_cmp++;
    if (n != 48) begin
      n_bad++;
      $display("FAIL %s clear_len: got %0d cycles want 48", tag, n);
    end
    n_cmp++;
    if (t_ready !== 1'b1 || s_busy !== 1'b1) begin
      n_bad++;
      $display("FAIL %s write_entry: t_ready=%b busy=%b want 1 1", tag, t_ready, s_busy);
    end
  endtask

  task automatic stream(input int first, input bit gaps, input string tag);
    int k, cyc;
    bit xfer;
    k = first;
    cyc = 0;
    while (k < 24 && cyc < 500) begin
      in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      in_grad  = 11'(grads[k]);
      start    = (k == pulse_at);
      xfer     = in_valid && s_ready;
      tick();
      if (xfer) k++;
      cyc++;
    end
    start = 1'b0;
    in_valid = 1'b0;
    n_cmp++;
    if (k != 24) begin
      n_bad++;
      $display("FAIL %s stream_timeout: got %0d samples want 24", tag, k);
    end
    n_cmp++;
    if (s_done !== 1'b1 || t_done !== 1'b1 || s_ready !== 1'b0 || s_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL %s frame_end: done=%b/%b ready=%b busy=%b want 1/1 0 0", tag, s_done, t_done, s_ready, s_busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_grad = 11'd0; rd_addr = 6'd0;
    tick();
    tick();
    n_cmp++;
    if (s_busy !== 1'b0 || s_ready !== 1'b0 || s_done !== 1'b0 || s_rd !== 8'd0 || t_rd !== 8'd0) begin
      n_bad++;
      $display("FAIL reset_values: busy=%b ready=%b done=%b rd=%0d/%0d want 0 0 0 0/0", s_busy, s_ready, s_done, s_rd, t_rd);
    end
    rst = 1'b0;
    tick();
    n_cmp++;
    if (s_busy !== 1'b0 || t_busy !== 1'b0 || s_done !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_after_reset: busy=%b/%b done=%b want 0/0 0", s_busy, t_busy, s_done);
    end
  endtask

  task automatic test_clear();
    for (int i = 0; i < 64; i++) begin
      dut.u_ram.r_mem[i]   = 8'hAA;
      dut_t.u_ram.r_mem[i] = 8'hAA;
    end
    for (int k = 0; k < 24; k++) grads[k] = 0;
    start_frame("clear");
    verify_frame("clear");
  endtask

  task automatic test_stream();
    int addrs [5] = '{9, 14, 17, 38, 46};
    int want  [5] = '{0, 5, 6, 23, 0};
    for (int k = 0; k < 24; k++) grads[k] = k;
    stream(0, 1'b0, "cont");
    for (int i = 0; i < 5; i++) begin
      rd_addr = 6'(addrs[i]);
      tick();
      n_cmp++;
      if (s_rd !== 8'(want[i])) begin
        n_bad++;
        $display("FAIL cont_spot addr %0d: got %0d want %0d", addrs[i], s_rd, want[i]);
      end
    end
    verify_frame("cont");
  endtask

  task automatic test_saturation();
    int addrs [6] = '{9, 10, 11, 12, 13, 14};
    int ws    [6] = '{255, 255, 255, 99, 100, 255};
    int wt    [6] = '{255, 255, 255, 0, 255, 255};
    grads[0] = 300; grads[1] = 255; grads[2] = 2047;
    grads[3] = 99;  grads[4] = 100; grads[5] = 1500;
    for (int k = 6; k < 24; k++) grads[k] = k * 11;
    start_frame("sat");
    stream(0, 1'b0, "sat");
    for (int i = 0; i < 6; i++) begin
      rd_addr = 6'(addrs[i]);
      tick();
      n_cmp++;
      if (s_rd !== 8'(ws[i]) || t_rd !== 8'(wt[i])) begin
        n_bad++;
        $display("FAIL sat_spot addr %0d: got %0d/%0d want %0d/%0d", addrs[i], s_rd, t_rd, ws[i], wt[i]);
      end
    end
    verify_frame("sat");
  endtask

  task automatic test_gaps();
    for (int k = 0; k < 24; k++) grads[k] = k;
    start_frame("gaps");
    pulse_at = 12;
    stream(0, 1'b1, "gaps");
    pulse_at = -1;
    in_valid = 1'b1;
    in_grad  = 11'd2047;
    for (int i = 0; i < 5; i++) tick();
    n_cmp++;
    if (s_ready !== 1'b0 || s_done !== 1'b1) begin
      n_bad++;
      $display("FAIL done_valid: ready=%b done=%b want 0 1", s_ready, s_done);
    end
    in_valid = 1'b0;
    verify_frame("gaps");
  endtask

  task automatic test_reset_mid_and_rdw();
    for (int k = 0; k < 24; k++) grads[k] = 200 - k * 7;
    start_frame("rstmid");
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1;
      in_grad  = 11'(grads[k]);
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    n_cmp++;
    if (s_busy !== 1'b0 || s_ready !== 1'b0 || s_done !== 1'b0 || t_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_mid: busy=%b ready=%b done=%b t_busy=%b want 0 0 0 0", s_busy, s_ready, s_done, t_busy);
    end
    tick();
    start_frame("restart");
    // First sample of the new frame targets addr 9 while addr 9 is being read.
    rd_addr  = 6'd9;
    in_valid = 1'b1;
    in_grad  = 11'(grads[0]);
    tick();
    in_valid = 1'b0;
    n_cmp++;
    if (s_rd !== 8'd0 || t_rd !== 8'd0) begin
      n_bad++;
      $display("FAIL rdw_old: got %0d/%0d want 0/0", s_rd, t_rd);
    end
    tick();
    n_cmp++;
    if (s_rd !== 8'd200 || t_rd !== 8'd255) begin
      n_bad++;
      $display("FAIL rdw_new: got %0d/%0d want 200/255", s_rd, t_rd);
    end
    stream(1, 1'b0, "restart");
    verify_frame("restart");
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_clear();
    test_stream();
    test_saturation();
    test_gaps();
    test_reset_mid_and_rdw();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
